// File: rtl/uart_pkg.sv
// Shared types and constants for the UART line receiver.
// Holds the deserializer state encoding and the baud divider rounding helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam int         OVS      = 16;

    // Rounded clocks per oversample tick, never below one.
    function automatic int calc_div(input int clk_hz, input int baud);
        int div;
        div = (clk_hz + (baud * OVS) / 2) / (baud * OVS);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_line_rx_if.sv
// Consumer-facing bundle of uart_line_rx: byte strobes, held-line status and read port.
// master = receiver side, slave = consumer side.
interface uart_line_rx_if #(
    parameter int LINE_MAX = 16
);
    localparam int LEN_W  = $clog2(LINE_MAX + 1);
    localparam int ADDR_W = $clog2(LINE_MAX);

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              line_valid;
    logic [LEN_W-1:0]  line_len;
    logic              line_trunc;
    logic [ADDR_W-1:0] line_rd_addr;
    logic [7:0]        line_rd_data;
    logic              line_ack;
    logic              overrun;

    modport master (
        output rx_data, rx_valid, frame_err, line_valid, line_len,
               line_trunc, line_rd_data, overrun,
        input  line_rd_addr, line_ack
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, line_valid, line_len,
               line_trunc, line_rd_data, overrun,
        output line_rd_addr, line_ack
    );

endinterface

// File: rtl/uart_rx_core.sv
// Synchronizer, oversample tick divider and serial deserializer (8N1).
// Defining UART_RX_PARITY_EN switches the frame to 8E1 with a PARITY state.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       frame_err_o
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OVS_W = $clog2(OVS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OVS_W-1:0] OVS_HALF = OVS_W'(OVS / 2 - 1);
    localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);

    logic [1:0]       sync_q;
    logic             rx_prev_q;
    logic [DIV_W-1:0] div_q;
    logic             rx_s;
    logic             fall;
    logic             tick;

    rx_state_t        state_q, state_d;
    logic [OVS_W-1:0] ovs_q, ovs_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
    logic             par_err_q, par_err_d;
`endif

    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             stop_sample;

    assign rx_s = sync_q[1];
    assign fall = rx_prev_q & ~rx_s;
    assign tick = (div_q == DIV_LAST);

    // Synchronizer resets to idle-high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            div_q     <= '0;
        end else begin
            sync_q    <= {sync_q[0], uart_rx_i};
            rx_prev_q <= rx_s;
            div_q     <= tick ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ovs_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ovs_q       <= ovs_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ovs_d   = ovs_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    ovs_d   = '0;
                end
            end
            START: begin
                // Re-check at mid start bit; a high line here was only a glitch.
                if (tick) begin
                    if (ovs_q == OVS_HALF) begin
                        ovs_d = '0;
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        par_err_d = 1'b0;
`endif
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        ovs_d = ovs_q + OVS_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (ovs_q == OVS_LAST) begin
                        ovs_d   = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        ovs_d = ovs_q + OVS_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (ovs_q == OVS_LAST) begin
                        ovs_d     = '0;
                        par_err_d = ^{shift_q, rx_s};
                        state_d   = STOP;
                    end else begin
                        ovs_d = ovs_q + OVS_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (ovs_q == OVS_LAST) begin
                        ovs_d   = '0;
                        state_d = rx_s ? IDLE : BREAK;
                    end else begin
                        ovs_d = ovs_q + OVS_W'(1);
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stop_sample = (state_q == STOP) && tick && (ovs_q == OVS_LAST);
`ifdef UART_RX_PARITY_EN
        rx_valid_d  = stop_sample && rx_s && !par_err_q;
        frame_err_d = stop_sample && (!rx_s || par_err_q);
`else
        rx_valid_d  = stop_sample && rx_s;
        frame_err_d = stop_sample && !rx_s;
`endif
        rx_data_d   = rx_valid_d ? shift_q : rx_data_q;
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: rtl/uart_line_rx.sv
// UART receiver with line assembly: bytes collect into a buffer until CR/LF, then the line is held until acked.
// Build option: UART_RX_PARITY_EN selects 8E1 framing in uart_rx_core.
module uart_line_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int LINE_MAX = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           uart_rx,
    uart_line_rx_if.master bus
);

    localparam int LEN_W  = $clog2(LINE_MAX + 1);
    localparam int ADDR_W = $clog2(LINE_MAX);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(LINE_MAX);

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             frame_err;
    logic             is_term;
    logic             wr_en;
    logic [7:0]       rd_data;
    logic [7:0]       buf_w [LINE_MAX];

    logic             line_valid_q, line_valid_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             trunc_q, trunc_d;
    logic             overrun_q, overrun_d;

    uart_rx_core #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rx_i   (uart_rx),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .frame_err_o (frame_err)
    );

    assign is_term = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);

    always_comb begin
        line_valid_d = line_valid_q;
        len_d        = len_q;
        trunc_d      = trunc_q;
        overrun_d    = 1'b0;
        wr_en        = 1'b0;
        if (rx_valid) begin
            if (line_valid_q) begin
                overrun_d = 1'b1;
            end else if (is_term) begin
                // Empty terminators are swallowed so CRLF produces a single line.
                if (len_q != '0) begin
                    line_valid_d = 1'b1;
                end
            end else if (len_q < LEN_MAX) begin
                wr_en = 1'b1;
                len_d = len_q + LEN_W'(1);
            end else begin
                trunc_d = 1'b1;
            end
        end
        if (bus.line_ack && line_valid_q) begin
            line_valid_d = 1'b0;
            len_d        = '0;
            trunc_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_valid_q <= 1'b0;
            len_q        <= '0;
            trunc_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            line_valid_q <= line_valid_d;
            len_q        <= len_d;
            trunc_q      <= trunc_d;
            overrun_q    <= overrun_d;
        end
    end

    for (genvar gi = 0; gi < LINE_MAX; gi++) begin : g_buf
        logic [7:0] entry_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_q <= '0;
            end else if (wr_en && (len_q == LEN_W'(gi))) begin
                entry_q <= rx_data;
            end
        end

        assign buf_w[gi] = entry_q;
    end

    // Explicit mux keeps out-of-range addresses harmless when LINE_MAX is not a power of two.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < LINE_MAX; i++) begin
            if (bus.line_rd_addr == ADDR_W'(i)) begin
                rd_data = buf_w[i];
            end
        end
    end

    assign bus.rx_data      = rx_data;
    assign bus.rx_valid     = rx_valid;
    assign bus.frame_err    = frame_err;
    assign bus.line_valid   = line_valid_q;
    assign bus.line_len     = len_q;
    assign bus.line_trunc   = trunc_q;
    assign bus.overrun      = overrun_q;
    assign bus.line_rd_data = rd_data;

endmodule

// File: tb/tb_uart_line_rx.sv
// Directed bench for uart_line_rx: text lines, glitch, framing error, truncation, overrun, mid-frame reset.
// Baud chosen so the tick divider is exact (4 clocks/tick, 64 clocks/bit) to keep run time short.
module tb_uart_line_rx;

    localparam int CLK_HZ   = 50_000_000;
    localparam int BAUD     = 781_250;
    localparam int LINE_MAX = 16;
    localparam int BIT_T    = 1280;

    logic clk;
    logic rst_n;
    logic uart_rx;

    int total = 0;
    int bad   = 0;
    int rx_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] last_data = '0;
    int base_rx, base_ferr, base_ovr;

    uart_line_rx_if #(.LINE_MAX(LINE_MAX)) bus ();

    uart_line_rx #(
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD),
        .LINE_MAX (LINE_MAX)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .uart_rx (uart_rx),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_cnt++;
            last_data = bus.rx_data;
            $display("rx byte 0x%02h", bus.rx_data);
        end
        if (bus.frame_err) begin
            ferr_cnt++;
            $display("frame error strobe");
        end
        if (bus.overrun) begin
            ovr_cnt++;
            $display("overrun strobe");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int nbits);
        uart_rx = 1'b1;
        #(nbits * BIT_T);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic odd);
        uart_rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            #(BIT_T);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = (^d) ^ odd;
        #(BIT_T);
`else
        if (odd) $display("odd parity requested without parity build");
`endif
        uart_rx = stop;
        #(BIT_T);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, 1'b1, 1'b0);
        idle(1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic rd_chk(input string tag, input int addr, input logic [7:0] exp);
        bus.line_rd_addr = 4'(addr);
        #1;
        chk(tag, {24'h0, bus.line_rd_data}, {24'h0, exp});
    endtask

    task automatic ack_line();
        @(negedge clk);
        bus.line_ack = 1'b1;
        @(negedge clk);
        bus.line_ack = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        uart_rx = 1'b1;
        bus.line_ack = 1'b0;
        bus.line_rd_addr = '0;
        repeat (5) @(negedge clk);

        chk("rst_rx_data",    bus.rx_data,    0);
        chk("rst_rx_valid",   bus.rx_valid,   0);
        chk("rst_frame_err",  bus.frame_err,  0);
        chk("rst_line_valid", bus.line_valid, 0);
        chk("rst_line_len",   bus.line_len,   0);
        chk("rst_line_trunc", bus.line_trunc, 0);
        chk("rst_overrun",    bus.overrun,    0);
        rst_n = 1'b1;
        idle(2);

        // "Hello\r\n": LF arrives while the line is held, so it is dropped as an overrun.
        send_str("Hello");
        send_byte(8'h0D);
        send_byte(8'h0A);
        chk("hello_rx_cnt",   rx_cnt,         7);
        chk("hello_valid",    bus.line_valid, 1);
        chk("hello_len",      bus.line_len,   5);
        chk("hello_trunc",    bus.line_trunc, 0);
        chk("hello_overrun",  ovr_cnt,        1);
        rd_chk("hello_rd0", 0, 8'h48);
        rd_chk("hello_rd1", 1, 8'h65);
        rd_chk("hello_rd2", 2, 8'h6C);
        rd_chk("hello_rd3", 3, 8'h6C);
        rd_chk("hello_rd4", 4, 8'h6F);
        ack_line();
        chk("hello_ack_valid", bus.line_valid, 0);
        chk("hello_ack_len",   bus.line_len,   0);

        // Quarter-bit glitch, then 0xA5.
        uart_rx = 1'b0;
        #(BIT_T / 4);
        idle(2);
        chk("glitch_rx_cnt",   rx_cnt,   7);
        chk("glitch_ferr_cnt", ferr_cnt, 0);
        send_byte(8'hA5);
        chk("a5_rx_cnt", rx_cnt,    8);
        chk("a5_data",   last_data, 8'hA5);

        // 0x55 with stop bit low, line low two more bit times, then 0x31.
        send_frame(8'h55, 1'b0, 1'b0);
        uart_rx = 1'b0;
        #(2 * BIT_T);
        idle(1);
        chk("ferr_cnt",    ferr_cnt, 1);
        chk("ferr_rx_cnt", rx_cnt,   8);
        send_byte(8'h31);
        chk("after_ferr_data",   bus.rx_data, 8'h31);
        chk("after_ferr_rx_cnt", rx_cnt,      9);
        send_byte(8'h0D);
        chk("a5_31_valid", bus.line_valid, 1);
        chk("a5_31_len",   bus.line_len,   2);
        rd_chk("a5_31_rd0", 0, 8'hA5);
        rd_chk("a5_31_rd1", 1, 8'h31);
        ack_line();

        // 20 x 'A' + CR against a 16-byte buffer.
        for (int i = 0; i < 20; i++) send_byte(8'h41);
        send_byte(8'h0D);
        chk("trunc_valid", bus.line_valid, 1);
        chk("trunc_len",   bus.line_len,   16);
        chk("trunc_flag",  bus.line_trunc, 1);
        for (int i = 0; i < 16; i++) rd_chk($sformatf("trunc_rd%0d", i), i, 8'h41);
        ack_line();
        chk("trunc_ack_flag", bus.line_trunc, 0);
        chk("trunc_ack_len",  bus.line_len,   0);

        // Held "ab", then "cd\r" is dropped byte by byte.
        send_str("ab");
        send_byte(8'h0D);
        chk("ab_len", bus.line_len, 2);
        base_ovr = ovr_cnt;
        send_str("cd");
        send_byte(8'h0D);
        chk("ovr_pulses", ovr_cnt - base_ovr, 3);
        chk("ovr_len",    bus.line_len,       2);
        rd_chk("ovr_rd0", 0, 8'h61);
        rd_chk("ovr_rd1", 1, 8'h62);
        ack_line();
        send_str("ef");
        send_byte(8'h0D);
        chk("ef_valid", bus.line_valid, 1);
        chk("ef_len",   bus.line_len,   2);
        rd_chk("ef_rd0", 0, 8'h65);
        rd_chk("ef_rd1", 1, 8'h66);
        ack_line();

        // Hold "x", then reset during data bit 4 of a frame.
        send_str("x");
        send_byte(8'h0D);
        chk("x_valid", bus.line_valid, 1);
        uart_rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            uart_rx = 1'(i % 2);
            #(BIT_T);
        end
        uart_rx = 1'b1;
        #(BIT_T / 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_line_valid", bus.line_valid, 0);
        chk("midrst_line_len",   bus.line_len,   0);
        chk("midrst_rx_data",    bus.rx_data,    0);
        chk("midrst_rx_valid",   bus.rx_valid,   0);
        chk("midrst_trunc",      bus.line_trunc, 0);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        rd_chk("midrst_buf0", 0, 8'h00);
        base_rx = rx_cnt;
        send_byte(8'h7E);
        chk("post_rst_data",   bus.rx_data,      8'h7E);
        chk("post_rst_rx_cnt", rx_cnt - base_rx, 1);
`ifdef UART_RX_PARITY_EN
        base_rx = rx_cnt;
        base_ferr = ferr_cnt;
        send_frame(8'h7E, 1'b1, 1'b1);
        idle(1);
        chk("par_ferr",   ferr_cnt - base_ferr, 1);
        chk("par_rx_cnt", rx_cnt - base_rx,     0);
`else
        base_ferr = ferr_cnt;
        chk("no_par_ferr", ferr_cnt - base_ferr + bus.frame_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
